// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multicycle RV32I datapath. It walks each instruction
// through fetch, decode, execute, memory and writeback for LW, SW, R-type,
// I-type ALU, BEQ and JAL. It drives the operand/result mux selects, the
// write enables and the memory request.
//
// Outputs are decoded from the registered state only, with two exceptions:
//   - in FETCH, ir_write/pc_write are qualified by mem_ready (the fetch commits
//     in the cycle the memory completes);
//   - in BRANCH, pc_write follows the ALU zero flag.
// Because the outputs come straight from the state register, asserting rst_n
// low drops mem_req in the same instant, without waiting for a clock edge.
//
// Memory handshake: mem_req is the valid and mem_ready is the ready. A request
// completes on a rising edge where both are 1. While mem_req=1 and mem_ready=0
// the state holds, so mem_req, mem_we and addr_sel stay stable for the whole
// wait. mem_ready is ignored whenever mem_req=0. Each state visit issues at
// most one request.
//
// Parameters:
//   STATE_W    width of the state debug output (encoding needs 4 bits)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   opcode     IR[6:0] of the latched instruction
//   zero       ALU zero flag
//   mem_ready  memory completes the current request this cycle
//   pc_write   load PC from result mux
//   ir_write   load IR from memory read data
//   mem_req    memory request, held until mem_ready
//   mem_we     request is a write
//   addr_sel   memory address: 0 = PC, 1 = ALUOut
//   reg_write  write rd from result mux
//   src_a_sel  ALU A: 00 PC, 01 oldPC, 10 rs1
//   src_b_sel  ALU B: 00 rs2, 01 imm, 10 constant 4
//   result_sel result mux: 00 ALUOut reg, 01 mem read data, 10 ALU result
//   alu_op     00 add, 01 sub, 10 funct-decoded
//   illegal    unsupported opcode trapped (sticky until reset)
//   state      current state, for debug
//
// Optional feature (macro MULTICYCLE_CTRL_PERF_EN):
//   retired    32-bit count of completed instructions
//   cycles     32-bit count of cycles spent outside IDLE/TRAP
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_req,
  output logic               mem_we,
  output logic               addr_sel,
  output logic               reg_write,
  output logic [1:0]         src_a_sel,
  output logic [1:0]         src_b_sel,
  output logic [1:0]         result_sel,
  output logic [1:0]         alu_op,
  output logic               illegal,
  output logic [STATE_W-1:0] state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]        retired,
  output logic [31:0]        cycles
`endif
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXECR  = 4'd7,
    S_EXECI  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_JALWB  = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  state_t cur_state;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
    end else begin
      case (cur_state)
        S_IDLE:   cur_state <= S_FETCH;
        S_FETCH:  if (mem_ready) cur_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: cur_state <= S_MEMADR;
            OP_R:         cur_state <= S_EXECR;
            OP_I:         cur_state <= S_EXECI;
            OP_BEQ:       cur_state <= S_BRANCH;
            OP_JAL:       cur_state <= S_JAL;
            default:      cur_state <= S_TRAP;
          endcase
        end
        // Only LW and SW reach MEMADR, and IR is stable, so one compare is enough.
        S_MEMADR: cur_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) cur_state <= S_MEMWB;
        S_MEMWB:  cur_state <= S_FETCH;
        S_MEMWR:  if (mem_ready) cur_state <= S_FETCH;
        S_EXECR:  cur_state <= S_ALUWB;
        S_EXECI:  cur_state <= S_ALUWB;
        S_ALUWB:  cur_state <= S_FETCH;
        S_BRANCH: cur_state <= S_FETCH;
        S_JAL:    cur_state <= S_JALWB;
        S_JALWB:  cur_state <= S_FETCH;
        S_TRAP:   cur_state <= S_TRAP;
        // The unused encodings 13 and 14 trap.
        default:  cur_state <= S_TRAP;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    reg_write  = 1'b0;
    src_a_sel  = 2'b00;
    src_b_sel  = 2'b00;
    result_sel = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        // PC+4 goes straight through the result mux. It commits with the IR load.
        mem_req    = 1'b1;
        src_b_sel  = 2'b10;
        result_sel = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Compute the branch/jump target oldPC+imm early, into ALUOut.
        src_a_sel = 2'b01;
        src_b_sel = 2'b01;
      end
      S_MEMADR: begin
        src_a_sel = 2'b10;
        src_b_sel = 2'b01;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_sel = 2'b01;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      S_EXECR: begin
        src_a_sel = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        src_a_sel = 2'b10;
        src_b_sel = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        // rs1-rs2 sets zero. The target was left in ALUOut by DECODE.
        src_a_sel = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      S_JAL: begin
        // Load PC with the target in ALUOut. The ALU computes the link oldPC+4.
        pc_write  = 1'b1;
        src_a_sel = 2'b01;
        src_b_sel = 2'b10;
      end
      S_JALWB: begin
        reg_write = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = STATE_W'(cur_state);

`ifdef MULTICYCLE_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2^32)
  // ---------------------------------------------------------------------------
  logic retire_now;

  assign retire_now = (cur_state == S_MEMWB) || (cur_state == S_ALUWB) ||
                      (cur_state == S_BRANCH) || (cur_state == S_JALWB) ||
                      ((cur_state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= 32'd0;
      cycles  <= 32'd0;
    end else begin
      if (retire_now) retired <= retired + 32'd1;
      if ((cur_state != S_IDLE) && (cur_state != S_TRAP)) cycles <= cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_ctrl. It issues random instruction streams with
// random memory wait counts, plus directed reset, fetch-wait and trap cases.
// Every cycle's expected state and outputs are built from the per-instruction
// phase sequence and the per-phase output table. The optional performance
// counters are checked when MULTICYCLE_CTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int W = 19;  // {state[3:0], 15 control bits}

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_req, mem_we, addr_sel, reg_write, illegal;
  logic [1:0] src_a_sel, src_b_sel, result_sel, alu_op;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] retired, cycles;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .reg_write  (reg_write),
    .src_a_sel  (src_a_sel),
    .src_b_sel  (src_b_sel),
    .result_sel (result_sel),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .retired    (retired),
    .cycles     (cycles)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Counter model: what the counters read after the edge that leaves prev_st.
  int          prev_st = 0;
  logic        prev_rdy = 1'b0;
  logic [31:0] exp_retired = 32'd0;
  logic [31:0] exp_cycles = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control outputs each state must present:
  // {pc_write, ir_write, mem_req, mem_we, addr_sel, reg_write, a, b, res, op, illegal}
  function automatic logic [14:0] spec_outs(input int st, input logic rdy, input logic z);
    logic pcw, irw, req, we, asel, rw, ill;
    logic [1:0] sa, sb, rs, op;
    pcw = 0; irw = 0; req = 0; we = 0; asel = 0; rw = 0; ill = 0;
    sa = 0; sb = 0; rs = 0; op = 0;
    case (st)
      1:  begin req = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      2:  begin sa = 2'b01; sb = 2'b01; end
      3:  begin sa = 2'b10; sb = 2'b01; end
      4:  begin req = 1; asel = 1; end
      5:  begin rw = 1; rs = 2'b01; end
      6:  begin req = 1; we = 1; asel = 1; end
      7:  begin sa = 2'b10; op = 2'b10; end
      8:  begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
      9:  rw = 1;
      10: begin sa = 2'b10; op = 2'b01; pcw = z; end
      11: begin pcw = 1; sa = 2'b01; sb = 2'b10; end
      12: rw = 1;
      15: ill = 1;
      default: ;
    endcase
    return {pcw, irw, req, we, asel, rw, sa, sb, rs, op, ill};
  endfunction

  function automatic logic [W-1:0] observed();
    return {state, pc_write, ir_write, mem_req, mem_we, addr_sel, reg_write,
            src_a_sel, src_b_sel, result_sel, alu_op, illegal};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock cycle. Drive the inputs just after the edge, predict the cycle,
  // then compare before the falling edge.
  task automatic step(input int st, input logic rdy, input logic z, input string tag);
    logic [W-1:0] exp, obs;
    @(posedge clk);
    #1;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back({4'(st), spec_outs(st, rdy, z)});
    if (prev_st != 0 && prev_st != 15) exp_cycles = exp_cycles + 32'd1;
    if (prev_st == 5 || prev_st == 9 || prev_st == 10 || prev_st == 12 ||
        (prev_st == 6 && prev_rdy)) exp_retired = exp_retired + 32'd1;
    prev_st  = st;
    prev_rdy = rdy;
    #3;
    obs = observed();
    exp = exp_q.pop_front();
    check({tag, "_state"}, 32'(obs[18:15]), 32'(exp[18:15]));
    check({tag, "_outs"},  32'(obs[14:0]),  32'(exp[14:0]));
`ifdef MULTICYCLE_CTRL_PERF_EN
    check({tag, "_retired"}, retired, exp_retired);
    check({tag, "_cycles"},  cycles,  exp_cycles);
`endif
  endtask

  // Assert reset away from the clock edge, check that everything clears at
  // once, then release it just after an edge and check that IDLE is visible.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs",  32'(observed()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_st = 0;
    prev_rdy = 1'b0;
    exp_retired = 32'd0;
    exp_cycles = 32'd0;
    #2;
    check("idle_state", 32'(state), 32'd0);
    check("idle_outs",  32'(observed()), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("idle_retired", retired, 32'd0);
    check("idle_cycles",  cycles,  32'd0);
`endif
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction from FETCH back to FETCH: fw fetch wait cycles and mw data
  // memory wait cycles. The phase list comes from each instruction's definition.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++) step(1, 1'b0, rbit(), "fetch_wait");
    step(1, 1'b1, rbit(), "fetch");
    opcode = op;
    step(2, rbit(), rbit(), "decode");
    case (op)
      OP_LW: begin
        step(3, rbit(), rbit(), "lw_adr");
        for (int i = 0; i < mw; i++) step(4, 1'b0, rbit(), "lw_wait");
        step(4, 1'b1, rbit(), "lw_rd");
        step(5, rbit(), rbit(), "lw_wb");
      end
      OP_SW: begin
        step(3, rbit(), rbit(), "sw_adr");
        for (int i = 0; i < mw; i++) step(6, 1'b0, rbit(), "sw_wait");
        step(6, 1'b1, rbit(), "sw_wr");
      end
      OP_R: begin
        step(7, rbit(), rbit(), "r_exec");
        step(9, rbit(), rbit(), "r_wb");
      end
      OP_I: begin
        step(8, rbit(), rbit(), "i_exec");
        step(9, rbit(), rbit(), "i_wb");
      end
      OP_BEQ: step(10, rbit(), z, "beq");
      OP_JAL: begin
        step(11, rbit(), rbit(), "jal");
        step(12, rbit(), rbit(), "jal_wb");
      end
      default: for (int i = 0; i < 20; i++) step(15, rbit(), rbit(), "trap");
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [6:0] legal_ops [6];

  initial begin
    legal_ops[0] = OP_LW;  legal_ops[1] = OP_SW; legal_ops[2] = OP_R;
    legal_ops[3] = OP_I;   legal_ops[4] = OP_BEQ; legal_ops[5] = OP_JAL;

    do_reset();

    // Delayed fetch, then a zero-wait LW.
    run_instr(OP_LW, 3, 0, 1'b0);
    // Branch taken and not taken.
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_JAL, 0, 0, 1'b0);
    run_instr(OP_SW, 0, 2, 1'b0);

    // Random instruction stream.
    for (int n = 0; n < 80; n++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                $urandom_range(0, 3), rbit());
    end

    // Reset in the middle of an LW data-read wait.
    step(1, 1'b1, 1'b0, "fetch");
    opcode = OP_LW;
    step(2, 1'b0, 1'b0, "decode");
    step(3, 1'b0, 1'b0, "lw_adr");
    step(4, 1'b0, 1'b0, "lw_wait");
    step(4, 1'b0, 1'b0, "lw_wait");
    do_reset();
    run_instr(OP_R, 1, 0, 1'b0);

    // Unsupported opcode traps and stays trapped.
    run_instr(OP_SYS, 0, 0, 1'b0);

    // Reset leaves TRAP. The controller must work normally afterwards.
    do_reset();
    run_instr(OP_JAL, 0, 0, 1'b0);
    run_instr(OP_I, 2, 0, 1'b0);
    step(1, 1'b0, 1'b0, "fetch_tail");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
